pipe_ctrl: RTL

//  Central hazard/flush scheduler for the 5-stage pipeline. Collects stall and redirect

---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/pipe_ctrl_sat_counter.sv | 24 ++
 rtl/pipe_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control block.
//  - ctrl_state_e : scheduler state encoding (RUN / FLUSH)
//  - STALL_*      : bit positions inside the 4-bit hold vector {ex_mem,id_ex,if_id,pc}
//  - STALL_EX/ID/IF : canned hold vectors for the three stall sources
package pipe_ctrl_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } ctrl_state_e;

  localparam int STALL_PC    = 0;
  localparam int STALL_IFID  = 1;
  localparam int STALL_IDEX  = 2;
  localparam int STALL_EXMEM = 3;

  // EX busy holds everything upstream of EX, plus the PC.
  localparam logic [3:0] STALL_EX = 4'b0111;
  // Load-use hazard holds PC and if_id; id_ex receives a bubble.
  localparam logic [3:0] STALL_ID = 4'b0011;
  // Fetch not ready only holds the PC; if_id receives a NOP.
  localparam logic [3:0] STALL_IF = 4'b0001;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter used for the performance counters.
// Ports:
//  clk : clock
//  clr : synchronous clear (highest priority)
//  en  : count enable; the counter holds once it reaches all-ones
//  q   : current count
module pipe_ctrl_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard/flush scheduler for the 5-stage pipeline.
// Collects stall and redirect requests from fetch, decode and execute and drives
// the PC hold, the per-stage hold vector and the if_id / id_ex flush inputs.
// A jump raised while EX is busy is latched and replayed once EX releases.
// Ports:
//  clk, rst        : clock, synchronous active-high reset
//  ex_stall_i      : EX multi-cycle op busy
//  jump_req_i      : EX resolved a taken branch/jump, target on jump_addr_i
//  id_stall_i      : load-use hazard in ID
//  bus_wait_i      : instruction fetch not ready
//  stall_o         : hold vector {ex_mem,id_ex,if_id,pc}
//  if_id_flush_o   : load NOP into if_id
//  id_ex_flush_o   : load bubble into id_ex
//  jump_o          : PC load strobe, jump_addr_o is the load value (0 otherwise)
//  stall_cnt_o     : saturating count of cycles with any hold bit set
//  flush_cnt_o     : saturating count of applied jumps
//  state_dbg       : current scheduler state
// Control outputs are combinational from state + inputs so a request takes
// effect in the same cycle; all outputs are forced to 0 while rst is high.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_stall_i,
  input  logic             jump_req_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             id_stall_i,
  input  logic             bus_wait_i,
  output logic [3:0]       stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             jump_o,
  output logic [31:0]      jump_addr_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [15:0]      flush_cnt_o,
  output ctrl_state_e      state_dbg
);

  // The jump cycle itself is the first flush cycle; FLUSH covers the rest.
  localparam logic [2:0] FLUSH_LOAD  = 3'(FLUSH_CYCLES - 1);
  localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);

  ctrl_state_e state;
  logic        pend;
  logic [31:0] pend_addr;
  logic [2:0]  flush_left;
  logic        run_jump;

  assign state_dbg = state;

  // A jump is applied in RUN when EX is free and either a replay or a live
  // request is present; a pending replay wins and the live request is the
  // same instruction, so it is dropped.
  assign run_jump = (state == ST_RUN) && !ex_stall_i && (pend || jump_req_i);

  always_comb begin
    stall_o       = '0;
    if_id_flush_o = 1'b0;
    id_ex_flush_o = 1'b0;
    jump_o        = 1'b0;
    jump_addr_o   = '0;
    if (!rst) begin
      if (state == ST_RUN) begin
        if (ex_stall_i) begin
          stall_o = STALL_EX;
        end else if (pend) begin
          jump_o        = 1'b1;
          jump_addr_o   = pend_addr;
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
        end else if (jump_req_i) begin
          jump_o        = 1'b1;
          jump_addr_o   = jump_addr_i;
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
        end else if (id_stall_i) begin
          stall_o       = STALL_ID;
          id_ex_flush_o = 1'b1;
        end else if (bus_wait_i) begin
          stall_o       = STALL_IF;
          if_id_flush_o = 1'b1;
        end
      end else begin
        // Fetch is still returning wrong-path words: keep flushing if_id.
        if_id_flush_o = 1'b1;
        if (ex_stall_i) begin
          stall_o = STALL_EX;
        end else if (bus_wait_i) begin
          stall_o[STALL_PC] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      pend       <= 1'b0;
      pend_addr  <= '0;
      flush_left <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (ex_stall_i) begin
            // Only the first request is kept; later ones are repeats.
            if (jump_req_i && !pend) begin
              pend      <= 1'b1;
              pend_addr <= jump_addr_i;
            end
          end else if (run_jump) begin
            pend <= 1'b0;
            if (MULTI_FLUSH) begin
              state      <= ST_FLUSH;
              flush_left <= FLUSH_LOAD;
            end
          end
        end
        ST_FLUSH: begin
          // EX busy freezes the schedule; fetch wait does not.
          if (!ex_stall_i) begin
            flush_left <= flush_left - 3'd1;
            if (flush_left == 3'd1) begin
              state <= ST_RUN;
            end
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  pipe_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .en  (|stall_o),
    .q   (stall_cnt_o)
  );

  pipe_ctrl_sat_counter #(.W(16)) u_flush_cnt (
    .clk (clk),
    .clr (rst),
    .en  (jump_o),
    .q   (flush_cnt_o)
  );

endmodule
